axi_demultiplexer_multicast: RTL and testbench

- Packet-granular AXI4-Stream router. Successor to the single-select demultiplexer.
- Destination selects are queued in an internal FIFO of depth SELECT_DEPTH, so routing decisions for upcoming packets can be posted ahead of the data.
- Each select is a destination bitmask, which gives unicast, multicast (lockstep per beat) and drop (mask zero).
- Sits between a producer and NUM_STREAMS consumer pipelines.

---
 rtl/axi_demultiplexer_multicast.sv | 101 ++++++++++
 tb/tb_axi_demultiplexer_multicast.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_demultiplexer_multicast.sv
// Packet-granular AXI4-Stream router: a queued destination bitmask per packet
// selects unicast, lockstep multicast, or drop (mask zero).
module axi_demultiplexer_multicast #(
  parameter int NUM_STREAMS  = 4,
  parameter int SELECT_DEPTH = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    select_valid,
  output logic                                    select_ready,
  input  logic [NUM_STREAMS-1:0]                  select_data,
  input  logic                                    in_tvalid,
  output logic                                    in_tready,
  input  logic [DATA_WIDTH-1:0]                   in_tdata,
  input  logic [DATA_WIDTH/8-1:0]                 in_tkeep,
  input  logic                                    in_tlast,
  output logic [NUM_STREAMS-1:0]                  out_tvalid,
  input  logic [NUM_STREAMS-1:0]                  out_tready,
  output logic [NUM_STREAMS*DATA_WIDTH-1:0]       out_tdata,
  output logic [NUM_STREAMS*(DATA_WIDTH/8)-1:0]   out_tkeep,
  output logic [NUM_STREAMS-1:0]                  out_tlast,
  output logic [$clog2(SELECT_DEPTH+1)-1:0]       select_level,
  output logic [COUNT_WIDTH-1:0]                  drop_count
);

  localparam int PTR_W = $clog2(SELECT_DEPTH);
  localparam int LVL_W = $clog2(SELECT_DEPTH+1);

  logic [NUM_STREAMS-1:0] mem [SELECT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [NUM_STREAMS-1:0] done;
  logic [NUM_STREAMS-1:0] head_mask;
  logic                   head_valid, full;
  logic                   push, pop, beat;

  assign full       = (select_level == LVL_W'(SELECT_DEPTH));
  assign head_valid = (select_level != '0);
  assign head_mask  = mem[rd_ptr];

  // Reset gates ready combinationally so no mask is taken while rst_n is low.
  assign select_ready = rst_n && !full;
  assign push         = select_valid && select_ready;
  assign beat         = in_tvalid && in_tready;
  assign pop          = beat && in_tlast;

  assign out_tdata = {NUM_STREAMS{in_tdata}};
  assign out_tkeep = {NUM_STREAMS{in_tkeep}};
  assign out_tlast = {NUM_STREAMS{in_tlast}};

  always_comb begin
    in_tready  = head_valid;
    out_tvalid = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      out_tvalid[i] = in_tvalid && head_valid && head_mask[i] && !done[i];
      if (head_mask[i] && !done[i] && !out_tready[i])
        in_tready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= select_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      select_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        select_level <= select_level + LVL_W'(1);
      else if (pop && !push)
        select_level <= select_level - LVL_W'(1);
    end
  end

  // done marks outputs that already took the current beat so they never see it twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done <= '0;
    else if (beat)
      done <= '0;
    else
      done <= done | (out_tvalid & out_tready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= '0;
    else if (pop && head_mask == '0)
      drop_count <= drop_count + COUNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_axi_demultiplexer_multicast.sv
// Bench for axi_demultiplexer_multicast: per-output scoreboard queues filled as
// beats are driven and drained as each output handshakes.
module tb_axi_demultiplexer_multicast;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW/8;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              select_valid = 0;
  logic              select_ready;
  logic [N-1:0]      select_data = '0;
  logic              in_tvalid = 0;
  logic              in_tready;
  logic [DW-1:0]     in_tdata = '0;
  logic [KW-1:0]     in_tkeep = '0;
  logic              in_tlast = 0;
  logic [N-1:0]      out_tvalid;
  logic [N-1:0]      out_tready = '1;
  logic [N*DW-1:0]   out_tdata;
  logic [N*KW-1:0]   out_tkeep;
  logic [N-1:0]      out_tlast;
  logic [2:0]        select_level;
  logic [31:0]       drop_count;

  axi_demultiplexer_multicast #(
    .NUM_STREAMS(N), .SELECT_DEPTH(4), .COUNT_WIDTH(32), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .select_valid(select_valid), .select_ready(select_ready), .select_data(select_data),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .select_level(select_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drop = 0;
  logic [DW+KW:0] sb [N][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the head of that output's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (out_tvalid[i] && out_tready[i]) begin
          if (sb[i].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out%0d_unexpected: got beat %0h expected none", i, out_tdata[i*DW +: DW]);
          end else begin
            check($sformatf("out%0d_beat", i),
                  {out_tlast[i], out_tkeep[i*KW +: KW], out_tdata[i*DW +: DW]},
                  sb[i].pop_front());
          end
        end
      end
    end
  end

  task automatic push_mask(input logic [N-1:0] m);
    bit got;
    int cyc = 0;
    select_valid = 1;
    select_data  = m;
    do begin
      @(negedge clk); got = select_ready;
      @(posedge clk); #1; cyc++;
    end while (!got && cyc < 200);
    if (!got) check("push_timeout", 0, 1);
    select_valid = 0;
  endtask

  task automatic expect_beat(input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[i]) sb[i].push_back({in_tlast, in_tkeep, in_tdata});
  endtask

  task automatic send_packet(input logic [N-1:0] m, input int beats, input bit rnd, output int cycles);
    bit got;
    cycles = 0;
    for (int b = 0; b < beats; b++) begin
      in_tvalid = 1;
      in_tdata  = $urandom;
      in_tkeep  = KW'($urandom);
      in_tlast  = (b == beats - 1);
      expect_beat(m);
      do begin
        @(negedge clk); got = in_tready;
        @(posedge clk); #1; cycles++;
        if (rnd) out_tready = N'($urandom);
      end while (!got && cycles < 200 * beats);
      if (!got) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
    in_tvalid  = 0;
    in_tlast   = 0;
    out_tready = '1;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           beats;
    bit           rnd;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int cyc;

    vecs[0] = '{4'b0001, 1, 0};
    vecs[1] = '{4'b1111, 3, 1};
    vecs[2] = '{4'b0110, 2, 1};
    vecs[3] = '{4'b0000, 3, 0};
    vecs[4] = '{4'b1010, 4, 1};
    vecs[5] = '{4'b1000, 2, 0};
    vecs[6] = '{4'b0000, 1, 1};
    vecs[7] = '{4'b0101, 5, 1};

    // Reset state
    select_valid = 1;
    in_tvalid    = 1;
    #3;
    check("rst_select_ready", select_ready, 0);
    check("rst_in_tready", in_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_level", select_level, 0);
    check("rst_drop", drop_count, 0);
    select_valid = 0;
    in_tvalid    = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Unicast to out[2]
    push_mask(4'b0100);
    @(negedge clk);
    check("uni_level_before", select_level, 1);
    @(posedge clk); #1;
    send_packet(4'b0100, 3, 0, cyc);
    check("uni_cycles", cyc, 3);
    check("uni_level_after", select_level, 0);

    // Queue-ahead to full
    push_mask(4'b0001);
    push_mask(4'b0010);
    push_mask(4'b0100);
    push_mask(4'b1000);
    @(negedge clk);
    check("full_ready", select_ready, 0);
    check("full_level", select_level, 4);
    @(posedge clk); #1;
    send_packet(4'b0001, 1, 0, cyc);
    @(negedge clk);
    check("unfull_ready", select_ready, 1);
    check("unfull_level", select_level, 3);
    @(posedge clk); #1;
    send_packet(4'b0010, 1, 0, cyc);
    send_packet(4'b0100, 1, 0, cyc);
    send_packet(4'b1000, 1, 0, cyc);
    check("drain_level", select_level, 0);

    // Table-driven packets
    foreach (vecs[k]) begin
      push_mask(vecs[k].mask);
      send_packet(vecs[k].mask, vecs[k].beats, vecs[k].rnd, cyc);
      if (vecs[k].mask == '0) begin
        exp_drop++;
        check($sformatf("vec%0d_drop_rate", k), cyc, vecs[k].beats);
      end
      check($sformatf("vec%0d_drop_count", k), drop_count, exp_drop);
    end
    check("table_level", select_level, 0);

    // Multicast skew: out[1] stalls while out[0] takes the beat once
    push_mask(4'b0011);
    in_tvalid  = 1;
    in_tdata   = 32'hCAFE_0011;
    in_tkeep   = '1;
    in_tlast   = 1;
    out_tready = 4'b0001;
    expect_beat(4'b0011);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("skew_tvalid%0d", k), out_tvalid, (k == 0) ? 4'b0011 : 4'b0010);
      check($sformatf("skew_tready%0d", k), in_tready, 0);
      @(posedge clk); #1;
    end
    out_tready = 4'b0011;
    @(negedge clk);
    check("skew_tvalid_final", out_tvalid, 4'b0010);
    check("skew_tready_final", in_tready, 1);
    @(posedge clk); #1;
    in_tvalid  = 0;
    out_tready = '1;
    check("skew_level", select_level, 0);

    // Drop two packets, deliver the third
    push_mask(4'b0000);
    push_mask(4'b0000);
    push_mask(4'b0001);
    for (int p = 0; p < 3; p++) begin
      send_packet((p == 2) ? 4'b0001 : 4'b0000, 2, 0, cyc);
      check($sformatf("drop_pkt%0d_cycles", p), cyc, 2);
    end
    exp_drop += 2;
    check("drop_count_after", drop_count, exp_drop);

    // Empty stall, then a late mask is not usable in its push cycle
    in_tvalid = 1;
    in_tdata  = 32'h5A5A_0008;
    in_tkeep  = '1;
    in_tlast  = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_tready%0d", k), in_tready, 0);
      check($sformatf("stall_tvalid%0d", k), out_tvalid, 0);
      @(posedge clk); #1;
    end
    select_valid = 1;
    select_data  = 4'b1000;
    @(negedge clk);
    check("late_push_tvalid", out_tvalid, 0);
    check("late_push_ready", select_ready, 1);
    @(posedge clk); #1;
    select_valid = 0;
    expect_beat(4'b1000);
    @(negedge clk);
    check("late_head_tvalid", out_tvalid, 4'b1000);
    check("late_head_tready", in_tready, 1);
    @(posedge clk); #1;
    in_tvalid = 0;

    // Asynchronous reset during beat 2
    push_mask(4'b0001);
    in_tvalid = 1;
    in_tdata  = 32'h0000_B001;
    in_tlast  = 0;
    expect_beat(4'b0001);
    @(negedge clk);
    check("mid_beat1_tready", in_tready, 1);
    @(posedge clk); #1;
    in_tdata   = 32'h0000_B002;
    out_tready = '0;
    #2 rst_n = 0;
    #1;
    check("arst_out_tvalid", out_tvalid, 0);
    check("arst_in_tready", in_tready, 0);
    check("arst_select_ready", select_ready, 0);
    check("arst_level", select_level, 0);
    check("arst_drop", drop_count, 0);
    in_tvalid  = 0;
    out_tready = '1;
    exp_drop   = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_level", select_level, 0);
    check("post_rst_drop", drop_count, exp_drop);
    check("post_rst_ready", select_ready, 1);

    for (int i = 0; i < N; i++)
      check($sformatf("sb%0d_empty", i), sb[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
